lockstep_pair_sequencer: RTL and testbench

//  Sequences entry into and exit from dual-core lockstep for NB_PAIRS core pairs.

---
 rtl/lockstep_pair_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_lockstep_pair_sequencer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/lockstep_pair_sequencer.sv
// lockstep_pair_sequencer
// Sequences entry into and exit from dual-core lockstep for NB_PAIRS core pairs.
// Each pair runs its own FSM (IDLE, SYNC, FLUSH, LOCKED, FAULT, UNLOCK).
// The FSM parks both cores at the event-unit barrier, drains them for FLUSH_CYCLES,
// then enters lockstep. A comparator mismatch while locked holds a sticky fault.
// Optional feature macro: LOCKSTEP_TIMEOUT_EN builds a per-pair SYNC watchdog.
// When the macro is not defined, SYNC waits indefinitely and timeout_o is tied to 0.
// All outputs are registered. Their values are decoded from the next state.

module lockstep_pair_sequencer #(
    parameter int NB_PAIRS       = 4,
    parameter int FLUSH_CYCLES   = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NB_PAIRS-1:0]   enter_req_i,
    input  logic [NB_PAIRS-1:0]   exit_req_i,
    input  logic [2*NB_PAIRS-1:0] barrier_matched_i,
    input  logic [NB_PAIRS-1:0]   mismatch_i,
    output logic [2*NB_PAIRS-1:0] halt_o,
    output logic [NB_PAIRS-1:0]   flush_o,
    output logic [NB_PAIRS-1:0]   lockstep_mode_o,
    output logic [NB_PAIRS-1:0]   fault_o,
    output logic [NB_PAIRS-1:0]   timeout_o,
    output logic                  busy_o
);

    localparam int CNT_LIMIT = (FLUSH_CYCLES > TIMEOUT_CYCLES) ? FLUSH_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W     = $clog2(CNT_LIMIT + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_CYCLES - 1);
`ifdef LOCKSTEP_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SYNC   = 3'd1,
        ST_FLUSH  = 3'd2,
        ST_LOCKED = 3'd3,
        ST_FAULT  = 3'd4,
        ST_UNLOCK = 3'd5
    } state_t;

    // Saturating increment: the counter sticks at all-ones and never wraps to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
        logic [CNT_W-1:0] res;
        if (val == CNT_MAX) begin
            res = val;
        end else begin
            res = val + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return res;
    endfunction

    logic [NB_PAIRS-1:0] busy_nxt_s;
    logic                busy_r;

    for (genvar p = 0; p < NB_PAIRS; p++) begin : g_pair
        state_t           state_r;
        state_t           state_nxt_s;
        logic [CNT_W-1:0] cnt_r;
        logic [CNT_W-1:0] cnt_nxt_s;
        logic             both_parked_s;
        logic [1:0]       halt_r;
        logic             flush_r;
        logic             lock_r;
        logic             fault_r;

        assign both_parked_s = barrier_matched_i[2*p] & barrier_matched_i[2*p+1];

`ifdef LOCKSTEP_TIMEOUT_EN
        logic tmo_nxt_s;
        logic tmo_r;
`endif

        // Next-state and counter logic for this pair.
        always_comb begin
            state_nxt_s = state_r;
            cnt_nxt_s   = cnt_r;
`ifdef LOCKSTEP_TIMEOUT_EN
            tmo_nxt_s   = 1'b0;
`endif
            case (state_r)
                ST_IDLE: begin
                    cnt_nxt_s = CNT_ZERO;
                    if (enter_req_i[p]) begin
                        state_nxt_s = ST_SYNC;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_SYNC: begin
                    // Abort beats a barrier match arriving in the same cycle.
                    if (exit_req_i[p]) begin
                        state_nxt_s = ST_IDLE;
                        cnt_nxt_s   = CNT_ZERO;
                    end else if (both_parked_s) begin
                        state_nxt_s = ST_FLUSH;
                        cnt_nxt_s   = CNT_ZERO;
                    end else begin
`ifdef LOCKSTEP_TIMEOUT_EN
                        if (cnt_r >= TMO_LAST) begin
                            state_nxt_s = ST_IDLE;
                            cnt_nxt_s   = CNT_ZERO;
                            tmo_nxt_s   = 1'b1;
                        end else begin
                            state_nxt_s = ST_SYNC;
                            cnt_nxt_s   = sat_inc(cnt_r);
                        end
`else
                        state_nxt_s = ST_SYNC;
                        cnt_nxt_s   = CNT_ZERO;
`endif
                    end
                end
                ST_FLUSH: begin
                    if (cnt_r >= FLUSH_LAST) begin
                        state_nxt_s = ST_LOCKED;
                        cnt_nxt_s   = CNT_ZERO;
                    end else begin
                        state_nxt_s = ST_FLUSH;
                        cnt_nxt_s   = sat_inc(cnt_r);
                    end
                end
                ST_LOCKED: begin
                    cnt_nxt_s = CNT_ZERO;
                    // A mismatch outranks an exit request seen in the same cycle.
                    if (mismatch_i[p]) begin
                        state_nxt_s = ST_FAULT;
                    end else if (exit_req_i[p]) begin
                        state_nxt_s = ST_UNLOCK;
                    end else begin
                        state_nxt_s = ST_LOCKED;
                    end
                end
                ST_FAULT: begin
                    cnt_nxt_s = CNT_ZERO;
                    if (exit_req_i[p]) begin
                        state_nxt_s = ST_UNLOCK;
                    end else begin
                        state_nxt_s = ST_FAULT;
                    end
                end
                ST_UNLOCK: begin
                    cnt_nxt_s   = CNT_ZERO;
                    state_nxt_s = ST_IDLE;
                end
                default: begin
                    cnt_nxt_s   = CNT_ZERO;
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end

        // State, counter and registered pair outputs, decoded from the next state.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                state_r <= ST_IDLE;
                cnt_r   <= CNT_ZERO;
                halt_r  <= 2'b00;
                flush_r <= 1'b0;
                lock_r  <= 1'b0;
                fault_r <= 1'b0;
`ifdef LOCKSTEP_TIMEOUT_EN
                tmo_r   <= 1'b0;
`endif
            end else begin
                state_r <= state_nxt_s;
                cnt_r   <= cnt_nxt_s;
                halt_r  <= ((state_nxt_s == ST_SYNC) || (state_nxt_s == ST_FLUSH) ||
                            (state_nxt_s == ST_FAULT)) ? 2'b11 : 2'b00;
                flush_r <= (state_nxt_s == ST_FLUSH);
                lock_r  <= (state_nxt_s == ST_LOCKED) || (state_nxt_s == ST_FAULT);
                fault_r <= (state_nxt_s == ST_FAULT);
`ifdef LOCKSTEP_TIMEOUT_EN
                tmo_r   <= tmo_nxt_s;
`endif
            end
        end

        assign busy_nxt_s[p]          = (state_nxt_s != ST_IDLE);
        assign halt_o[2*p+1:2*p]      = halt_r;
        assign flush_o[p]             = flush_r;
        assign lockstep_mode_o[p]     = lock_r;
        assign fault_o[p]             = fault_r;
`ifdef LOCKSTEP_TIMEOUT_EN
        assign timeout_o[p]           = tmo_r;
`endif
    end

`ifndef LOCKSTEP_TIMEOUT_EN
    assign timeout_o = {NB_PAIRS{1'b0}};
`endif

    // Registered busy flag: set when any pair will be outside IDLE after this edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_r <= 1'b0;
        end else begin
            busy_r <= |busy_nxt_s;
        end
    end

    assign busy_o = busy_r;

endmodule

// File: tb/tb_lockstep_pair_sequencer.sv
// Scoreboard bench for lockstep_pair_sequencer (NB_PAIRS=4, FLUSH_CYCLES=8, TIMEOUT_CYCLES=16).
// The stimulus pushes hand-computed output snapshots, tagged with a cycle number, into a queue.
// A monitor on the falling edge pops and compares each snapshot in the cycle it is due.

module tb_lockstep_pair_sequencer;

    logic       clk_i;
    logic       rst_i;
    logic [3:0] enter_req_i;
    logic [3:0] exit_req_i;
    logic [7:0] barrier_matched_i;
    logic [3:0] mismatch_i;
    logic [7:0] halt_o;
    logic [3:0] flush_o;
    logic [3:0] lockstep_mode_o;
    logic [3:0] fault_o;
    logic [3:0] timeout_o;
    logic       busy_o;

    lockstep_pair_sequencer #(
        .NB_PAIRS       (4),
        .FLUSH_CYCLES   (8),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .enter_req_i       (enter_req_i),
        .exit_req_i        (exit_req_i),
        .barrier_matched_i (barrier_matched_i),
        .mismatch_i        (mismatch_i),
        .halt_o            (halt_o),
        .flush_o           (flush_o),
        .lockstep_mode_o   (lockstep_mode_o),
        .fault_o           (fault_o),
        .timeout_o         (timeout_o),
        .busy_o            (busy_o)
    );

    typedef struct packed {
        int           cyc;
        logic [127:0] name;
        logic [7:0]   halt;
        logic [3:0]   flush;
        logic [3:0]   lock;
        logic [3:0]   fault;
        logic [3:0]   tmo;
        logic         busy;
    } exp_t;

    exp_t exp_q[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
        cyc = cyc + 1;
    endtask

    task automatic goto(input int c);
        while (cyc < c) tick();
    endtask

    // Queue an expected output snapshot for cycle c, kept sorted by cycle.
    task automatic expect_at(input int c, input logic [127:0] nm, input logic [7:0] h,
                             input logic [3:0] f, input logic [3:0] l, input logic [3:0] ft,
                             input logic [3:0] t, input logic b);
        exp_t e;
        int   idx;
        logic found;
        e.cyc = c; e.name = nm; e.halt = h; e.flush = f;
        e.lock = l; e.fault = ft; e.tmo = t; e.busy = b;
        idx   = exp_q.size();
        found = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (!found && exp_q[i].cyc > c) begin
                idx   = i;
                found = 1'b1;
            end
        end
        exp_q.insert(idx, e);
    endtask

    // Monitor: compare every snapshot due in the current cycle; flag any that were skipped.
    always @(negedge clk_i) begin
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            total = total + 1;
            bad   = bad + 1;
            $display("FAIL %0s: due at cycle %0d but never compared (now %0d)", e.name, e.cyc, cyc);
        end
        while (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            e = exp_q.pop_front();
            total = total + 1;
            if (halt_o !== e.halt || flush_o !== e.flush || lockstep_mode_o !== e.lock ||
                fault_o !== e.fault || timeout_o !== e.tmo || busy_o !== e.busy) begin
                bad = bad + 1;
                $display("FAIL %0s cyc=%0d got halt=%h flush=%b lock=%b fault=%b tmo=%b busy=%b want halt=%h flush=%b lock=%b fault=%b tmo=%b busy=%b",
                         e.name, cyc, halt_o, flush_o, lockstep_mode_o, fault_o, timeout_o, busy_o,
                         e.halt, e.flush, e.lock, e.fault, e.tmo, e.busy);
            end
        end
    end

    initial begin
        rst_i = 1'b1; enter_req_i = 4'b0000; exit_req_i = 4'b0000;
        barrier_matched_i = 8'h00; mismatch_i = 4'b0000;

        // Reset state
        expect_at(2, "reset_a", 8'h00, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        expect_at(3, "reset_b", 8'h00, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        goto(3); rst_i = 1'b0;

        // Pair 0 entry: enter at 10, partial barrier at 15, full match at 20
        expect_at(10, "t1_idle",     8'h00, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        expect_at(11, "t1_sync",     8'h03, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1);
        expect_at(16, "t1_partial",  8'h03, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1);
        expect_at(20, "t1_presync",  8'h03, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1);
        expect_at(21, "t1_flush0",   8'h03, 4'h1, 4'h0, 4'h0, 4'h0, 1'b1);
        expect_at(28, "t1_flush7",   8'h03, 4'h1, 4'h0, 4'h0, 4'h0, 1'b1);
        expect_at(29, "t1_lock",     8'h00, 4'h0, 4'h1, 4'h0, 4'h0, 1'b1);
        goto(10); enter_req_i = 4'b0001;
        goto(11); enter_req_i = 4'b0000;
        goto(15); barrier_matched_i = 8'h01;
        goto(16); barrier_matched_i = 8'h00;
        goto(20); barrier_matched_i = 8'h03;
        goto(21); barrier_matched_i = 8'h00;

        // Pair 1 locks, then exit on pairs 0,1 (and ignored exit on idle pair 3)
        expect_at(33, "t2_flush",    8'h0C, 4'h2, 4'h1, 4'h0, 4'h0, 1'b1);
        expect_at(41, "t2_lock",     8'h00, 4'h0, 4'h3, 4'h0, 4'h0, 1'b1);
        expect_at(51, "t2_unlock",   8'h00, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1);
        expect_at(52, "t2_idle",     8'h00, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        goto(30); enter_req_i = 4'b0010;
        goto(31); enter_req_i = 4'b0000;
        goto(32); barrier_matched_i = 8'h0C;
        goto(33); barrier_matched_i = 8'h00;
        goto(50); exit_req_i = 4'b1011;
        goto(51); exit_req_i = 4'b0000;

        // Pair 2: mismatch and exit together -> fault wins, sticky until exit
        expect_at(66, "t3_lock",     8'h00, 4'h0, 4'h4, 4'h0, 4'h0, 1'b1);
        expect_at(71, "t3_fault",    8'h30, 4'h0, 4'h4, 4'h4, 4'h0, 1'b1);
        expect_at(74, "t3_sticky",   8'h30, 4'h0, 4'h4, 4'h4, 4'h0, 1'b1);
        expect_at(76, "t3_unlock",   8'h00, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1);
        expect_at(77, "t3_idle",     8'h00, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        goto(55); enter_req_i = 4'b0100;
        goto(56); enter_req_i = 4'b0000;
        goto(57); barrier_matched_i = 8'h30;
        goto(58); barrier_matched_i = 8'h00;
        goto(70); mismatch_i = 4'b0101; exit_req_i = 4'b0100;
        goto(71); mismatch_i = 4'b0000; exit_req_i = 4'b0000;
        goto(75); exit_req_i = 4'b0100;
        goto(76); exit_req_i = 4'b0000;

        // Pair 3 half-parked (watchdog), pair 1 abort beats a same-cycle match
        expect_at(84, "t4_two_sync", 8'hCC, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1);
        expect_at(86, "t4_abort",    8'hC0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1);
        expect_at(96, "t4_wd_last",  8'hC0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1);
`ifdef LOCKSTEP_TIMEOUT_EN
        expect_at(97, "t4_timeout",  8'h00, 4'h0, 4'h0, 4'h0, 4'h8, 1'b0);
        expect_at(98, "t4_tmo_end",  8'h00, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
`else
        expect_at(97, "t4_no_tmo",   8'hC0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1);
        expect_at(98, "t4_still",    8'hC0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1);
`endif
        expect_at(101, "t4_idle",    8'h00, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        goto(80); enter_req_i = 4'b1000;
        goto(81); enter_req_i = 4'b0000; barrier_matched_i = 8'h40;
        goto(82); enter_req_i = 4'b0010;
        goto(83); enter_req_i = 4'b0000;
        goto(85); exit_req_i = 4'b0010; barrier_matched_i = 8'h4C;
        goto(86); exit_req_i = 4'b0000; barrier_matched_i = 8'h40;
        goto(100); exit_req_i = 4'b1000; barrier_matched_i = 8'h00;
        goto(101); exit_req_i = 4'b0000;

        // Match on the last watchdog cycle still goes to FLUSH
        expect_at(126, "wd_pre",     8'h03, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1);
        expect_at(127, "wd_match",   8'h03, 4'h1, 4'h0, 4'h0, 4'h0, 1'b1);
        expect_at(135, "wd_lock",    8'h00, 4'h0, 4'h1, 4'h0, 4'h0, 1'b1);
        goto(110); enter_req_i = 4'b0001;
        goto(111); enter_req_i = 4'b0000;
        goto(126); barrier_matched_i = 8'h03;
        goto(127); barrier_matched_i = 8'h00;

        // All pairs requested at once (pair 0 already locked), staggered matches
        expect_at(141, "t5_sync",    8'hFC, 4'h0, 4'h1, 4'h0, 4'h0, 1'b1);
        expect_at(144, "t5_p1_flush",8'hFC, 4'h2, 4'h1, 4'h0, 4'h0, 1'b1);
        expect_at(151, "t5_flush3",  8'hFC, 4'hE, 4'h1, 4'h0, 4'h0, 1'b1);
        expect_at(152, "t5_p1_lock", 8'hF0, 4'hC, 4'h3, 4'h0, 4'h0, 1'b1);
        expect_at(154, "t5_p2_lock", 8'hC0, 4'h8, 4'h7, 4'h0, 4'h0, 1'b1);
        expect_at(155, "t5_p3_last", 8'hC0, 4'h8, 4'h7, 4'h0, 4'h0, 1'b1);
        expect_at(156, "t5_all_lock",8'h00, 4'h0, 4'hF, 4'h0, 4'h0, 1'b1);
        goto(140); enter_req_i = 4'b1111;
        goto(141); enter_req_i = 4'b0000;
        goto(143); barrier_matched_i = 8'h0C;
        goto(144); barrier_matched_i = 8'h00;
        goto(145); barrier_matched_i = 8'h30;
        goto(146); barrier_matched_i = 8'h00;
        goto(147); barrier_matched_i = 8'hC0;
        goto(148); barrier_matched_i = 8'h00;

        // Reset with pairs 0..2 locked and pair 3 mid-FLUSH
        expect_at(159, "t6_unlock",  8'h00, 4'h0, 4'h7, 4'h0, 4'h0, 1'b1);
        expect_at(166, "t6_midflush",8'hC0, 4'h8, 4'h7, 4'h0, 4'h0, 1'b1);
        expect_at(167, "t6_reset",   8'h00, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        expect_at(168, "t6_after",   8'h00, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        goto(158); exit_req_i = 4'b1000;
        goto(159); exit_req_i = 4'b0000;
        goto(161); enter_req_i = 4'b1000;
        goto(162); enter_req_i = 4'b0000;
        goto(163); barrier_matched_i = 8'hC0;
        goto(164); barrier_matched_i = 8'h00;
        goto(165); mismatch_i = 4'b1000; exit_req_i = 4'b1000;
        goto(166); mismatch_i = 4'b0000; exit_req_i = 4'b0000; rst_i = 1'b1;
        goto(167); rst_i = 1'b0;

        goto(170);
        for (int i = 0; i < 5; i++) begin
            if (exp_q.size() > 0) tick();
        end
        if (exp_q.size() != 0) begin
            total = total + 1;
            bad   = bad + 1;
            $display("FAIL drain: %0d expectations still pending, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
